// File: rtl/hysteresis_counter_table_pkg.sv
// -----------------------------------------------------------------------------
// hysteresis_counter_package
// Shared types and the counter next-state rule for the hysteresis counter
// table (branch-predictor pattern history table).
//   state_t          : table FSM states (INIT sweeps the array, READY serves).
//   hysteresis_next  : next value of one counter after a taken/not-taken
//                      training event.
// -----------------------------------------------------------------------------
package hysteresis_counter_package;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  // Counters live in 0..range_states-1 with the decision threshold at
  // half = range_states/2. Crossing the threshold jumps past it by
  // 'coercivity' extra steps, so a single contrary outcome right after a
  // direction change cannot flip the prediction back.
  function automatic int hysteresis_next(input int count, input logic taken,
                                         input int range_states,
                                         input int coercivity);
    int half;
    half = range_states / 2;
    if (taken) begin
      if (count == range_states - 1) return count;
      if (count == half - 1) return half + coercivity;
      return count + 1;
    end else begin
      if (count == 0) return count;
      if (count == half) return half - 1 - coercivity;
      return count - 1;
    end
  endfunction

endpackage

// File: rtl/hysteresis_counter_next.sv
// -----------------------------------------------------------------------------
// hysteresis_counter_next
// Combinational next-state for one hysteresis counter on the update path.
// Ports:
//   count      in  current counter value
//   taken      in  1 = train towards taken, 0 = towards not-taken
//   next_count out trained counter value
// -----------------------------------------------------------------------------
module hysteresis_counter_next
  import hysteresis_counter_package::*;
#(
  parameter int RANGE      = 4,
  parameter int COERCIVITY = 1,
  parameter int CW         = $clog2(RANGE)
) (
  input  logic [CW-1:0] count,
  input  logic          taken,
  output logic [CW-1:0] next_count
);

  always_comb begin
    next_count = CW'(hysteresis_next(int'(count), taken, RANGE, COERCIVITY));
  end

endmodule

// File: rtl/hysteresis_counter_table.sv
// -----------------------------------------------------------------------------
// hysteresis_counter_table
// DEPTH-entry table of hysteresis saturating counters. After reset an INIT
// sweep writes RESET_VALUE into every entry (one per cycle), then the table
// serves one lookup and one update per cycle.
// Ports:
//   clock, reset                      clock and synchronous active-high reset
//   lookup_valid/lookup_index         lookup request (fetch side)
//   lookup_ready                      1 once the INIT sweep has finished
//   prediction_valid/count/taken      registered lookup response, 1 cycle later
//   update_valid/index/taken          training request (commit side)
//   update_ready                      1 once the INIT sweep has finished
// Same-index lookup and update in one cycle: lookup returns the old value.
// -----------------------------------------------------------------------------
module hysteresis_counter_table
  import hysteresis_counter_package::*;
#(
  parameter int DEPTH       = 16,
  parameter int RANGE       = 4,
  parameter int RESET_VALUE = 1,
  parameter int COERCIVITY  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       lookup_valid,
  input  logic [$clog2(DEPTH)-1:0]   lookup_index,
  output logic                       lookup_ready,
  output logic                       prediction_valid,
  output logic [$clog2(RANGE)-1:0]   prediction_count,
  output logic                       prediction_taken,
  input  logic                       update_valid,
  input  logic [$clog2(DEPTH)-1:0]   update_index,
  input  logic                       update_taken,
  output logic                       update_ready
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(RANGE);

  logic [CW-1:0] entry_q [DEPTH];
  state_t        state;
  logic [IW-1:0] init_ptr;
  logic          ready_q;

  logic          lookup_fire;
  logic          update_fire;
  logic [CW-1:0] update_next;

  logic          vld_p1;
  logic [CW-1:0] count_p1;
  logic          taken_p1;

  // ready_q is only ever set on the INIT->READY transition, so it doubles
  // as the "in READY" flag and keeps both ready outputs registered.
  assign lookup_ready = ready_q;
  assign update_ready = ready_q;
  assign lookup_fire  = lookup_valid && ready_q;
  assign update_fire  = update_valid && ready_q;

  hysteresis_counter_next #(
    .RANGE      (RANGE),
    .COERCIVITY (COERCIVITY),
    .CW         (CW)
  ) u_next (
    .count      (entry_q[update_index]),
    .taken      (update_taken),
    .next_count (update_next)
  );

  // ---- stage p0 -> p1: FSM, array write, lookup response register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      init_ptr <= '0;
      ready_q  <= 1'b0;
      vld_p1   <= 1'b0;
      count_p1 <= '0;
      taken_p1 <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          entry_q[init_ptr] <= CW'(RESET_VALUE);
          init_ptr          <= init_ptr + IW'(1);
          if (init_ptr == IW'(DEPTH - 1)) begin
            state   <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          if (update_fire) entry_q[update_index] <= update_next;
        end
        default: state <= INIT;
      endcase

      // The read samples the array before this edge's update lands,
      // giving read-before-write on an index collision.
      vld_p1 <= lookup_fire;
      if (lookup_fire) begin
        count_p1 <= entry_q[lookup_index];
        taken_p1 <= (entry_q[lookup_index] >= CW'(RANGE / 2));
      end
    end
  end

  assign prediction_valid = vld_p1;
  assign prediction_count = count_p1;
  assign prediction_taken = taken_p1;

endmodule

// File: tb/tb_hysteresis_counter_table.sv
module tb_hysteresis_counter_table;
  import hysteresis_counter_package::*;

  localparam int DEPTH = 16;
  localparam int RANGE = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       lookup_valid;
  logic [3:0] lookup_index;
  logic       lookup_ready;
  logic       prediction_valid;
  logic [1:0] prediction_count;
  logic       prediction_taken;
  logic       update_valid;
  logic [3:0] update_index;
  logic       update_taken;
  logic       update_ready;

  int total = 0;
  int bad   = 0;

  hysteresis_counter_table #(
    .DEPTH       (16),
    .RANGE       (4),
    .RESET_VALUE (1),
    .COERCIVITY  (1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .lookup_valid     (lookup_valid),
    .lookup_index     (lookup_index),
    .lookup_ready     (lookup_ready),
    .prediction_valid (prediction_valid),
    .prediction_count (prediction_count),
    .prediction_taken (prediction_taken),
    .update_valid     (update_valid),
    .update_index     (update_index),
    .update_taken     (update_taken),
    .update_ready     (update_ready)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic lookup(input int idx, input int exp_count, input string tag);
    lookup_valid = 1'b1;
    lookup_index = 4'(idx);
    tick();
    lookup_valid = 1'b0;
    check({tag, "_vld"}, 32'(prediction_valid), 32'd1);
    check({tag, "_cnt"}, 32'(prediction_count), 32'(exp_count));
    check({tag, "_tkn"}, 32'(prediction_taken), 32'(exp_count >= 2));
  endtask

  task automatic update(input int idx, input logic tkn);
    update_valid = 1'b1;
    update_index = 4'(idx);
    update_taken = tkn;
    tick();
    update_valid = 1'b0;
  endtask

  int model [DEPTH];
  int exp_c;
  logic lv, uv, ut;
  int li, ui;

  initial begin
    reset = 1'b1;
    lookup_valid = 1'b0; lookup_index = '0;
    update_valid = 1'b0; update_index = '0; update_taken = 1'b0;

    // Reset state
    tick();
    check("rst_lready", 32'(lookup_ready), 32'd0);
    check("rst_uready", 32'(update_ready), 32'd0);
    check("rst_pvld",   32'(prediction_valid), 32'd0);
    check("rst_pcnt",   32'(prediction_count), 32'd0);
    check("rst_ptkn",   32'(prediction_taken), 32'd0);
    reset = 1'b0;

    // INIT lasts exactly 16 cycles
    for (int i = 0; i < 16; i++) begin
      check("init_lready", 32'(lookup_ready), 32'd0);
      check("init_uready", 32'(update_ready), 32'd0);
      tick();
    end
    check("post_init_lready", 32'(lookup_ready), 32'd1);
    check("post_init_uready", 32'(update_ready), 32'd1);

    // Back-to-back lookups of every entry, one response per cycle
    for (int i = 0; i < 16; i++) lookup(i, 1, "init_read");
    tick();
    check("idle_pvld", 32'(prediction_valid), 32'd0);

    // Jump up: 1 -> 3, then saturate at 3
    update(5, 1'b1);
    lookup(5, 3, "jump_up");
    update(5, 1'b1);
    lookup(5, 3, "sat_hi");

    // Jump down: 3 -> 2 -> 0 -> 0
    update(5, 1'b0);
    lookup(5, 2, "dn_2");
    update(5, 1'b0);
    lookup(5, 0, "dn_jump0");
    update(5, 1'b0);
    lookup(5, 0, "sat_lo");

    // Same-cycle collision on index 7: read-before-write
    lookup_valid = 1'b1; lookup_index = 4'd7;
    update_valid = 1'b1; update_index = 4'd7; update_taken = 1'b1;
    tick();
    lookup_valid = 1'b0; update_valid = 1'b0;
    check("coll_vld", 32'(prediction_valid), 32'd1);
    check("coll_cnt", 32'(prediction_count), 32'd1);
    lookup(7, 3, "coll_after");
    lookup(8, 1, "coll_other");

    // Reset mid-operation
    update(2, 1'b1);
    update(9, 1'b1);
    lookup(2, 3, "pre_rst2");
    lookup_valid = 1'b1; lookup_index = 4'd9;
    tick();
    check("inflight_vld", 32'(prediction_valid), 32'd1);
    check("inflight_cnt", 32'(prediction_count), 32'd3);
    lookup_valid = 1'b0;
    reset = 1'b1;
    update_valid = 1'b1; update_index = 4'd3; update_taken = 1'b1;
    tick();
    update_valid = 1'b0;
    check("midrst_pvld",   32'(prediction_valid), 32'd0);
    check("midrst_pcnt",   32'(prediction_count), 32'd0);
    check("midrst_lready", 32'(lookup_ready), 32'd0);
    tick();
    check("rst_hold_ready", 32'(update_ready), 32'd0);
    reset = 1'b0;
    lookup_valid = 1'b1; lookup_index = 4'd2;
    for (int i = 0; i < 16; i++) begin
      check("reinit_ready", 32'(lookup_ready), 32'd0);
      tick();
      check("reinit_pvld", 32'(prediction_valid), 32'd0);
    end
    lookup_valid = 1'b0;
    check("reinit_done", 32'(lookup_ready), 32'd1);
    lookup(2, 1, "reinit_e2");
    lookup(9, 1, "reinit_e9");
    lookup(3, 1, "reinit_e3");

    // Random traffic against a model
    for (int i = 0; i < DEPTH; i++) model[i] = 1;
    for (int c = 0; c < 1000; c++) begin
      lv = 1'($urandom_range(0, 1));
      uv = 1'($urandom_range(0, 1));
      ut = 1'($urandom_range(0, 1));
      li = int'($urandom_range(0, DEPTH - 1));
      ui = int'($urandom_range(0, DEPTH - 1));
      lookup_valid = lv; lookup_index = 4'(li);
      update_valid = uv; update_index = 4'(ui); update_taken = ut;
      exp_c = model[li];
      if (uv) model[ui] = hysteresis_next(model[ui], ut, RANGE, 1);
      tick();
      check("rnd_vld", 32'(prediction_valid), 32'(lv));
      if (lv) begin
        check("rnd_cnt", 32'(prediction_count), 32'(exp_c));
        check("rnd_tkn", 32'(prediction_taken), 32'(exp_c >= 2));
      end
    end
    lookup_valid = 1'b0; update_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
